spi_adc_responder: RTL and testbench

- SPI mode-0 peripheral that answers the existing SPI master's ADC read frames: shifts a 12-bit sample out on MISO, captures the master's MOSI word.
- Used on-chip and in benches as a stand-in for the external ADC, so the SPI master, LED test and 7-segment path can be exercised in loopback.
- Samples the master's SCK/CS/MOSI, which are asynchronous to clk, through synchronisers. All logic runs on clk.

---
 rtl/spi_resp_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_adc_responder.sv | 167 ++++++++++++++++
 tb/tb_spi_adc_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI ADC responder.
package spi_resp_pkg;

    localparam int DEF_DATA_W  = 12;
    localparam int DEF_FRAME_W = 16;
    localparam int CNT_W       = 5;
    localparam int FCNT_W      = 8;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with registered
// rise/fall pulses aligned to the cycle the synchronised level changes.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            // Edge is taken between the last two stages so it lines up with level.
            rise   <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
            fall   <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 stand-in for the external ADC: returns a zero-padded sample on MISO
// and captures the master's MOSI word. Define SPI_RESP_RAMP_EN to return a ramp.
module spi_adc_responder
    import spi_resp_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FRAME_W     = DEF_FRAME_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_sck,
    input  logic               i_cs,
    input  logic               i_mosi,
    output logic               o_miso,
    output logic               o_miso_oe,
    input  logic [DATA_W-1:0]  i_sample,
    input  logic               i_sample_valid,
    output logic [FRAME_W-1:0] o_rx_data,
    output logic               o_frame_done,
    output logic               o_frame_err,
    output logic [FCNT_W-1:0]  o_frame_cnt,
    output logic [1:0]         o_state
);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .din(i_sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(i_cs),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(i_mosi),
        .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t              state, state_nxt;
    logic [FRAME_W-1:0]  tx, tx_nxt, rx, rx_nxt, rx_data, rx_data_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [FCNT_W-1:0]   fcnt, fcnt_nxt;
    logic                miso, miso_nxt, oe, oe_nxt, done_nxt, err_nxt;
    logic [DATA_W-1:0]   src;
    logic [FRAME_W-1:0]  frame_word;

`ifdef SPI_RESP_RAMP_EN
    logic [DATA_W-1:0] ramp;
    logic              unused_sample;
    assign unused_sample = ^{i_sample, i_sample_valid};

    always_ff @(posedge clk) begin
        if (reset)         ramp <= '0;
        else if (done_nxt) ramp <= ramp + 1'b1;
    end
    assign src = ramp;
`else
    logic [DATA_W-1:0] holding;

    // A load in the same cycle as frame start lands in the next frame.
    always_ff @(posedge clk) begin
        if (reset)               holding <= '0;
        else if (i_sample_valid) holding <= i_sample;
    end
    assign src = holding;
`endif

    assign frame_word = {{(FRAME_W-DATA_W){1'b0}}, src};

    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx;
        rx_nxt      = rx;
        cnt_nxt     = cnt;
        miso_nxt    = miso;
        oe_nxt      = oe;
        rx_data_nxt = rx_data;
        fcnt_nxt    = fcnt;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            WAIT_IDLE: begin
                // cs must read high for a full synchroniser flush before trusting it.
                miso_nxt = 1'b0;
                oe_nxt   = 1'b0;
                if (!cs_lvl) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_W'(SYNC_STAGES + 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE: begin
                miso_nxt = 1'b0;
                oe_nxt   = 1'b0;
                if (cs_fall) begin
                    tx_nxt    = frame_word;
                    rx_nxt    = '0;
                    miso_nxt  = frame_word[FRAME_W-1];
                    oe_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    miso_nxt  = 1'b0;
                    oe_nxt    = 1'b0;
                    state_nxt = IDLE;
                    if (cnt == CNT_W'(FRAME_W)) begin
                        rx_data_nxt = rx;
                        done_nxt    = 1'b1;
                        fcnt_nxt    = fcnt + 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (sck_rise) begin
                    rx_nxt = {rx[FRAME_W-2:0], mosi_lvl};
                    if (cnt != '1) cnt_nxt = cnt + 1'b1;
                end else if (sck_fall) begin
                    tx_nxt   = {tx[FRAME_W-2:0], 1'b0};
                    miso_nxt = tx[FRAME_W-2];
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_IDLE;
            tx           <= '0;
            rx           <= '0;
            cnt          <= '0;
            miso         <= 1'b0;
            oe           <= 1'b0;
            rx_data      <= '0;
            fcnt         <= '0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            tx           <= tx_nxt;
            rx           <= rx_nxt;
            cnt          <= cnt_nxt;
            miso         <= miso_nxt;
            oe           <= oe_nxt;
            rx_data      <= rx_data_nxt;
            fcnt         <= fcnt_nxt;
            o_frame_done <= done_nxt;
            o_frame_err  <= err_nxt;
        end
    end

    assign o_miso      = miso;
    assign o_miso_oe   = oe;
    assign o_rx_data   = rx_data;
    assign o_frame_cnt = fcnt;
    assign o_state     = state;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder acting as an SPI mode-0 master.
// Handshake: SPI pins are driven #1 after a clk edge; outputs are sampled off-edge.
module tb_spi_adc_responder;

    localparam int HALF = 4;

    logic        clk;
    logic        reset;
    logic        i_sck, i_cs, i_mosi;
    logic        o_miso, o_miso_oe;
    logic [11:0] i_sample;
    logic        i_sample_valid;
    logic [15:0] o_rx_data;
    logic        o_frame_done, o_frame_err;
    logic [7:0]  o_frame_cnt;
    logic [1:0]  o_state;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int err_seen = 0;
    int miso_bad = 0;
    int cs_high_clks = 0;

    spi_adc_responder dut (
        .clk(clk), .reset(reset),
        .i_sck(i_sck), .i_cs(i_cs), .i_mosi(i_mosi),
        .o_miso(o_miso), .o_miso_oe(o_miso_oe),
        .i_sample(i_sample), .i_sample_valid(i_sample_valid),
        .o_rx_data(o_rx_data), .o_frame_done(o_frame_done),
        .o_frame_err(o_frame_err), .o_frame_cnt(o_frame_cnt),
        .o_state(o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_frame_done) done_seen++;
        if (o_frame_err)  err_seen++;
        if (i_cs) cs_high_clks++;
        else      cs_high_clks = 0;
        if (cs_high_clks > 5 && o_miso !== 1'b0) miso_bad++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(8);
    endtask

    task automatic load_sample(input logic [11:0] v);
        @(posedge clk); #1;
        i_sample = v;
        i_sample_valid = 1'b1;
        wait_clks(1);
        i_sample_valid = 1'b0;
    endtask

    task automatic sck_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            i_sck = 1'b1;
            wait_clks(HALF);
            i_sck = 1'b0;
            wait_clks(HALF);
        end
    endtask

    // One frame of nbits; race pulses i_sample_valid in the cycle the DUT acts on cs fall.
    task automatic spi_frame(input int nbits, input logic [31:0] mosi_word,
                             input bit race, input logic [11:0] race_val,
                             output logic [31:0] miso_word, output bit oe_ok);
        miso_word = '0;
        oe_ok = 1'b1;
        @(posedge clk); #1;
        i_cs = 1'b0;
        i_mosi = mosi_word[nbits-1];
        if (race) begin
            wait_clks(2);
            i_sample = race_val;
            i_sample_valid = 1'b1;
            wait_clks(1);
            i_sample_valid = 1'b0;
            wait_clks(HALF - 3);
        end else begin
            wait_clks(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            i_sck = 1'b1;
            miso_word = {miso_word[30:0], o_miso};
            if (o_miso_oe !== 1'b1) oe_ok = 1'b0;
            wait_clks(HALF);
            i_sck = 1'b0;
            if (i < nbits - 1) i_mosi = mosi_word[nbits-2-i];
            wait_clks(HALF);
        end
        i_cs = 1'b1;
        i_mosi = 1'b0;
        wait_clks(8);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        wait_clks(3);
        checks++; if (o_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", o_miso); end
        checks++; if (o_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", o_miso_oe); end
        checks++; if (o_rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx: got %h want 0000", o_rx_data); end
        checks++; if ({o_frame_done, o_frame_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {o_frame_done, o_frame_err}); end
        checks++; if (o_frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", o_frame_cnt); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0 (WAIT_IDLE)", o_state); end
        reset = 1'b0;
        wait_clks(8);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL reset_to_idle: got %0d want 1 (IDLE)", o_state); end
    endtask

    task automatic test_basic_read();
        logic [31:0] rd;
        bit oe_ok;
        int d0, e0;
        load_sample(12'hA5C);
        d0 = done_seen; e0 = err_seen;
        spi_frame(16, 32'h1800, 1'b0, 12'h000, rd, oe_ok);
        checks++; if (rd !== 32'h0A5C) begin errors++; $display("FAIL basic_miso: got %h want 0a5c", rd); end
        checks++; if (oe_ok !== 1'b1) begin errors++; $display("FAIL basic_oe: got %b want 1", oe_ok); end
        checks++; if (o_rx_data !== 16'h1800) begin errors++; $display("FAIL basic_rx: got %h want 1800", o_rx_data); end
        checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_seen - d0); end
        checks++; if (err_seen - e0 !== 0) begin errors++; $display("FAIL basic_err: got %0d want 0", err_seen - e0); end
        checks++; if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", o_frame_cnt); end
        checks++; if (o_miso_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_end: got %b want 0", o_miso_oe); end
    endtask

    task automatic test_bad_length();
        logic [31:0] rd;
        bit oe_ok;
        int d0, e0;
        d0 = done_seen; e0 = err_seen;
        spi_frame(10, 32'h2AB, 1'b0, 12'h000, rd, oe_ok);
        checks++; if (rd !== 32'h029) begin errors++; $display("FAIL short_miso: got %h want 029", rd); end
        checks++; if (err_seen - e0 !== 1) begin errors++; $display("FAIL short_err: got %0d want 1", err_seen - e0); end
        checks++; if (done_seen - d0 !== 0) begin errors++; $display("FAIL short_done: got %0d want 0", done_seen - d0); end
        checks++; if (o_rx_data !== 16'h1800) begin errors++; $display("FAIL short_rx: got %h want 1800", o_rx_data); end
        checks++; if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL short_cnt: got %0d want 1", o_frame_cnt); end
        e0 = err_seen;
        spi_frame(18, 32'h3FFFF, 1'b0, 12'h000, rd, oe_ok);
        checks++; if (rd !== 32'h2970) begin errors++; $display("FAIL long_miso: got %h want 2970", rd); end
        checks++; if (err_seen - e0 !== 1) begin errors++; $display("FAIL long_err: got %0d want 1", err_seen - e0); end
        checks++; if (o_rx_data !== 16'h1800) begin errors++; $display("FAIL long_rx: got %h want 1800", o_rx_data); end
        d0 = done_seen;
        spi_frame(16, 32'h3C96, 1'b0, 12'h000, rd, oe_ok);
        checks++; if (rd !== 32'h0A5C) begin errors++; $display("FAIL after_short_miso: got %h want 0a5c", rd); end
        checks++; if (o_rx_data !== 16'h3C96) begin errors++; $display("FAIL after_short_rx: got %h want 3c96", o_rx_data); end
        checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL after_short_done: got %0d want 1", done_seen - d0); end
        checks++; if (o_frame_cnt !== 8'd2) begin errors++; $display("FAIL after_short_cnt: got %0d want 2", o_frame_cnt); end
    endtask

    task automatic test_sample_race();
        logic [31:0] rd;
        bit oe_ok;
        load_sample(12'hFFF);
        spi_frame(16, 32'h0001, 1'b1, 12'h123, rd, oe_ok);
        checks++; if (rd !== 32'h0FFF) begin errors++; $display("FAIL race_old: got %h want 0fff", rd); end
        spi_frame(16, 32'h0002, 1'b0, 12'h000, rd, oe_ok);
        checks++; if (rd !== 32'h0123) begin errors++; $display("FAIL race_new: got %h want 0123", rd); end
        checks++; if (o_rx_data !== 16'h0002) begin errors++; $display("FAIL race_rx: got %h want 0002", o_rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        bit oe_ok;
        int d0, e0;
        load_sample(12'h1FF);
        @(posedge clk); #1;
        i_cs = 1'b0;
        i_mosi = 1'b1;
        wait_clks(HALF);
        sck_pulses(7);
        checks++; if ({o_miso, o_miso_oe} !== 2'b11) begin errors++; $display("FAIL mid_pre: got %b want 11", {o_miso, o_miso_oe}); end
        reset = 1'b1;
        wait_clks(1);
        checks++; if ({o_miso, o_miso_oe} !== 2'b00) begin errors++; $display("FAIL mid_reset_out: got %b want 00", {o_miso, o_miso_oe}); end
        wait_clks(1);
        reset = 1'b0;
        d0 = done_seen; e0 = err_seen;
        sck_pulses(9);
        i_cs = 1'b1;
        i_mosi = 1'b0;
        wait_clks(10);
        checks++; if (done_seen - d0 + err_seen - e0 !== 0) begin errors++; $display("FAIL mid_no_pulse: got %0d pulses want 0", done_seen - d0 + err_seen - e0); end
        checks++; if (o_frame_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", o_frame_cnt); end
        checks++; if (o_rx_data !== 16'h0000) begin errors++; $display("FAIL mid_rx: got %h want 0000", o_rx_data); end
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL mid_state: got %0d want 1 (IDLE)", o_state); end
        spi_frame(16, 32'hBEEF, 1'b0, 12'h000, rd, oe_ok);
        checks++; if (rd !== 32'h0000) begin errors++; $display("FAIL mid_holding_cleared: got %h want 0000", rd); end
        checks++; if (o_rx_data !== 16'hBEEF) begin errors++; $display("FAIL mid_after_rx: got %h want beef", o_rx_data); end
        checks++; if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL mid_after_cnt: got %0d want 1", o_frame_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bit oe_ok, saw_wrap;
        logic [7:0] exp_cnt, prev;
        logic [15:0] w;
        saw_wrap = 1'b0;
        exp_cnt = 8'd1;
        load_sample(12'h5A3);
        for (int i = 0; i < 256; i++) begin
            w = 16'(i * 16'h0101) ^ 16'h8421;
            prev = o_frame_cnt;
            spi_frame(16, {16'h0, w}, 1'b0, 12'h000, rd, oe_ok);
            exp_cnt = exp_cnt + 8'd1;
            if (prev == 8'd255 && o_frame_cnt == 8'd0) saw_wrap = 1'b1;
            checks++; if (o_frame_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, o_frame_cnt, exp_cnt); end
            checks++; if (o_rx_data !== w) begin errors++; $display("FAIL b2b_rx[%0d]: got %h want %h", i, o_rx_data, w); end
            checks++; if (rd !== 32'h05A3) begin errors++; $display("FAIL b2b_miso[%0d]: got %h want 05a3", i, rd); end
        end
        checks++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL cnt_wrap: got %b want 1", saw_wrap); end
        checks++; if (miso_bad !== 0) begin errors++; $display("FAIL miso_idle: got %0d nonzero samples want 0", miso_bad); end
    endtask

    task automatic test_ramp();
        logic [31:0] rd;
        bit oe_ok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load_sample(12'hABC);
            spi_frame(16, 32'h00F0, 1'b1, 12'h777, rd, oe_ok);
            checks++; if (rd !== 32'(i)) begin errors++; $display("FAIL ramp[%0d]: got %h want %h", i, rd, 32'(i)); end
        end
        checks++; if (o_frame_cnt !== 8'd3) begin errors++; $display("FAIL ramp_cnt: got %0d want 3", o_frame_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        i_sck = 1'b0;
        i_cs = 1'b1;
        i_mosi = 1'b0;
        i_sample = '0;
        i_sample_valid = 1'b0;
        test_reset();
`ifdef SPI_RESP_RAMP_EN
        test_ramp();
`else
        test_basic_read();
        test_bad_length();
        test_sample_race();
        test_reset_mid_frame();
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
